// File: rtl/mmio_store_ctrl_pkg.sv
// Shared opcode/funct3 constants for the memory stage plus the MMIO offset map,
// so the store side here and the load-side io select decode the same addresses.
package mmio_store_ctrl_pkg;

  localparam logic [6:0] OPC_LOAD  = 7'b0000011;
  localparam logic [6:0] OPC_STORE = 7'b0100011;
  localparam logic [6:0] OPC_OPIMM = 7'b0010011;

  localparam logic [2:0] FNC_SB = 3'b000;
  localparam logic [2:0] FNC_SH = 3'b001;
  localparam logic [2:0] FNC_SW = 3'b010;
  localparam logic [2:0] FNC_LW = 3'b010;

  // MMIO offsets, relative to the MMIO window base
  localparam logic [31:0] UART_CTRL = 32'h0000_0000;
  localparam logic [31:0] UART_RX   = 32'h0000_0004;
  localparam logic [31:0] UART_TX   = 32'h0000_0008;
  localparam logic [31:0] CYCLE_CNT = 32'h0000_0010;
  localparam logic [31:0] INST_CNT  = 32'h0000_0014;
  localparam logic [31:0] CNT_RST   = 32'h0000_0018;

  // UART TX holding register occupancy
  typedef enum logic {
    TX_EMPTY = 1'b0,
    TX_FULL  = 1'b1
  } tx_state_e;

endpackage

// File: rtl/mmio_counters.sv
// Free-running cycle counter and retired-instruction counter with a
// synchronous clear that takes priority over the same-cycle increment.
module mmio_counters #(
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clr,
  input  logic             inst_inc,
  output logic [CNT_W-1:0] cycle_count,
  output logic [CNT_W-1:0] inst_count
);

  logic [CNT_W-1:0] cycle_q, cycle_d;
  logic [CNT_W-1:0] inst_q, inst_d;

  // Next counter values: clear wins, otherwise increment (wraps naturally)
  always_comb begin
    cycle_d = cycle_q + CNT_W'(1);
    inst_d  = inst_inc ? inst_q + CNT_W'(1) : inst_q;
    if (clr) begin
      cycle_d = '0;
      inst_d  = '0;
    end
  end

  // Counter registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cycle_q <= '0;
      inst_q  <= '0;
    end else begin
      cycle_q <= cycle_d;
      inst_q  <= inst_d;
    end
  end

  assign cycle_count = cycle_q;
  assign inst_count  = inst_q;

endmodule

// File: rtl/mmio_store_ctrl.sv
// Memory-stage store / MMIO-write control: byte masks and lane data for
// DMEM/IMEM, the UART TX holding register, RX consume pulse and counters.
//
// Handshakes (valid/ready): a byte transfers on a cycle where valid and ready
// are both high. TX: uart_tx_valid stays high with stable uart_tx_data until
// uart_tx_ready is seen. RX: uart_rx_ready is a single-cycle pulse, raised only
// while uart_rx_valid is high, so it always marks exactly one consumed byte.
module mmio_store_ctrl
  import mmio_store_ctrl_pkg::*;
#(
  parameter int          CNT_W     = 32,
  parameter logic [31:0] MMIO_BASE = 32'h8000_0000
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [31:0]      inst_mem,
  input  logic [31:0]      alu_mem,
  input  logic [31:0]      rs2_mem,
  input  logic             stall,
  input  logic             inst_retire,
  output logic [3:0]       st_mask,
  output logic [31:0]      st_data,
  output logic             dmem_wen,
  output logic             imem_wen,
  output logic [7:0]       uart_tx_data,
  output logic             uart_tx_valid,
  input  logic             uart_tx_ready,
  input  logic             uart_rx_valid,
  output logic             uart_rx_ready,
  output logic [31:0]      uart_ctrl,
  output logic [CNT_W-1:0] cycle_count,
  output logic [CNT_W-1:0] inst_count
);

  logic [6:0] opcode;
  logic [2:0] funct3;
  logic [1:0] off;
  logic       is_store;
  logic       is_load;
  logic       hit_tx;
  logic       hit_rx;
  logic       hit_cnt_rst;
  logic       unused_inst_bits;

  assign opcode   = inst_mem[6:0];
  assign funct3   = inst_mem[14:12];
  assign off      = alu_mem[1:0];
  assign is_store = (opcode == OPC_STORE) && !stall;
  assign is_load  = (opcode == OPC_LOAD) && !stall;

  // Full 32-bit compares so aliases inside the window never match
  assign hit_tx      = (alu_mem == MMIO_BASE + UART_TX);
  assign hit_rx      = (alu_mem == MMIO_BASE + UART_RX);
  assign hit_cnt_rst = (alu_mem == MMIO_BASE + CNT_RST);

  assign unused_inst_bits = ^{inst_mem[31:15], inst_mem[11:7]};

  // Byte-lane mask and replicated store data
  always_comb begin
    st_mask = 4'b0000;
    st_data = rs2_mem;
    case (funct3)
      FNC_SB: begin
        st_data = {4{rs2_mem[7:0]}};
        if (is_store) st_mask = 4'b0001 << off;
      end
      FNC_SH: begin
        st_data = {2{rs2_mem[15:0]}};
        if (is_store) st_mask = 4'b0011 << {off[1], 1'b0};
      end
      FNC_SW: begin
        if (is_store) st_mask = 4'b1111;
      end
      default: ;
    endcase
  end

  // MMIO (bit 31) never writes memory; bits 28/29 select DMEM/IMEM independently
  assign dmem_wen = is_store && !alu_mem[31] && alu_mem[28];
  assign imem_wen = is_store && !alu_mem[31] && alu_mem[29];

  // TX holding register: state and buffer
  tx_state_e  tx_state_q, tx_state_d;
  logic [7:0] tx_buf_q, tx_buf_d;

  // TX next state: load on store when empty, drain on handshake; stores while full are dropped
  always_comb begin
    tx_state_d = tx_state_q;
    tx_buf_d   = tx_buf_q;
    case (tx_state_q)
      TX_EMPTY: begin
        if (is_store && hit_tx) begin
          tx_buf_d   = rs2_mem[7:0];
          tx_state_d = TX_FULL;
        end
      end
      TX_FULL: begin
        if (uart_tx_ready) tx_state_d = TX_EMPTY;
      end
      default: tx_state_d = TX_EMPTY;
    endcase
  end

  // TX state register; async reset discards any pending byte
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tx_state_q <= TX_EMPTY;
      tx_buf_q   <= 8'h00;
    end else begin
      tx_state_q <= tx_state_d;
      tx_buf_q   <= tx_buf_d;
    end
  end

  // uart_tx_valid is the FSM state itself, so it doubles as the state observation point
  assign uart_tx_valid = (tx_state_q == TX_FULL);
  assign uart_tx_data  = tx_buf_q;

  // RX consume pulse, combinational; a stalled load waits until the stall lifts
  assign uart_rx_ready = is_load && hit_rx && uart_rx_valid;

  assign uart_ctrl = {30'b0, uart_rx_valid, !uart_tx_valid};

  mmio_counters #(
    .CNT_W(CNT_W)
  ) u_counters (
    .clk        (clk),
    .rst_n      (rst_n),
    .clr        (is_store && hit_cnt_rst),
    .inst_inc   (inst_retire && !stall),
    .cycle_count(cycle_count),
    .inst_count (inst_count)
  );

endmodule

// File: tb/tb_mmio_store_ctrl.sv
// Directed bench for mmio_store_ctrl: expected values go into a scoreboard
// queue as stimulus is applied and are popped when the outputs are sampled.
module tb_mmio_store_ctrl;
  import mmio_store_ctrl_pkg::*;

  localparam int W = 32;

  logic          clk;
  logic          rst_n;
  logic [31:0]   inst_mem;
  logic [31:0]   alu_mem;
  logic [31:0]   rs2_mem;
  logic          stall;
  logic          inst_retire;
  logic [3:0]    st_mask;
  logic [31:0]   st_data;
  logic          dmem_wen;
  logic          imem_wen;
  logic [7:0]    uart_tx_data;
  logic          uart_tx_valid;
  logic          uart_tx_ready;
  logic          uart_rx_valid;
  logic          uart_rx_ready;
  logic [31:0]   uart_ctrl;
  logic [31:0]   cycle_count;
  logic [31:0]   inst_count;

  logic [W-1:0] exp_q[$];
  int checks;
  int failures;

  localparam logic [31:0] NOP = {25'b0, OPC_OPIMM};

  mmio_store_ctrl #(
    .CNT_W    (32),
    .MMIO_BASE(32'h8000_0000)
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .inst_mem     (inst_mem),
    .alu_mem      (alu_mem),
    .rs2_mem      (rs2_mem),
    .stall        (stall),
    .inst_retire  (inst_retire),
    .st_mask      (st_mask),
    .st_data      (st_data),
    .dmem_wen     (dmem_wen),
    .imem_wen     (imem_wen),
    .uart_tx_data (uart_tx_data),
    .uart_tx_valid(uart_tx_valid),
    .uart_tx_ready(uart_tx_ready),
    .uart_rx_valid(uart_rx_valid),
    .uart_rx_ready(uart_rx_ready),
    .uart_ctrl    (uart_ctrl),
    .cycle_count  (cycle_count),
    .inst_count   (inst_count)
  );

  // Clock
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  function automatic logic [31:0] st_inst(input logic [2:0] f3);
    return {17'b0, f3, 5'b0, OPC_STORE};
  endfunction

  function automatic logic [31:0] ld_inst(input logic [2:0] f3);
    return {17'b0, f3, 5'b0, OPC_LOAD};
  endfunction

  // Driver tasks
  task automatic drive(input logic [31:0] inst, input logic [31:0] addr,
                       input logic [31:0] data, input logic stl, input logic ret);
    inst_mem    = inst;
    alu_mem     = addr;
    rs2_mem     = data;
    stall       = stl;
    inst_retire = ret;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input logic [W-1:0] v);
    exp_q.push_back(v);
  endtask

  // Scoreboard compare: pop the oldest expectation and check it
  task automatic chk(input string tag, input logic [W-1:0] obs);
    logic [W-1:0] expv;
    checks++;
    if (exp_q.size() == 0) begin
      failures++;
      $error("FAIL %s: observed=%h expected=<queue empty>", tag, obs);
    end else begin
      expv = exp_q.pop_front();
      assert (obs === expv) else begin
        failures++;
        $error("FAIL %s: observed=%h expected=%h", tag, obs, expv);
      end
    end
  endtask

  initial begin
    checks = 0;
    failures = 0;
    rst_n = 1'b0;
    uart_tx_ready = 1'b0;
    uart_rx_valid = 1'b0;
    drive(NOP, 32'h0, 32'h0, 1'b0, 1'b0);

    // Reset state
    #2;
    push(0); push(0); push(0); push(0);
    chk("rst_tx_valid", 32'(uart_tx_valid));
    chk("rst_rx_ready", 32'(uart_rx_ready));
    chk("rst_cycle", cycle_count);
    chk("rst_inst", inst_count);
    @(negedge clk);
    rst_n = 1'b1;

    // SB to DMEM, top byte lane
    step();
    drive(st_inst(FNC_SB), 32'h1000_0003, 32'h0000_00AB, 1'b0, 1'b0);
    push(32'h8); push(32'hABAB_ABAB); push(1); push(0);
    #2;
    chk("sb_mask", 32'(st_mask));
    chk("sb_data", st_data);
    chk("sb_dmem", 32'(dmem_wen));
    chk("sb_imem", 32'(imem_wen));

    // SH to DMEM+IMEM, upper half
    step();
    drive(st_inst(FNC_SH), 32'h3000_0002, 32'h0000_1234, 1'b0, 1'b0);
    push(32'hC); push(32'h1234_1234); push(1); push(1);
    #2;
    chk("sh_mask", 32'(st_mask));
    chk("sh_data", st_data);
    chk("sh_dmem", 32'(dmem_wen));
    chk("sh_imem", 32'(imem_wen));

    // SW to MMIO ctrl: mask driven, no memory write
    step();
    drive(st_inst(FNC_SW), 32'h8000_0000, 32'hDEAD_BEEF, 1'b0, 1'b0);
    push(32'hF); push(32'hDEAD_BEEF); push(0); push(0);
    #2;
    chk("sw_mmio_mask", 32'(st_mask));
    chk("sw_mmio_data", st_data);
    chk("sw_mmio_dmem", 32'(dmem_wen));
    chk("sw_mmio_imem", 32'(imem_wen));

    // SB lane 1, SH lower half to IMEM only
    step();
    drive(st_inst(FNC_SB), 32'h1000_0001, 32'h0000_005A, 1'b0, 1'b0);
    push(32'h2);
    #2;
    chk("sb_off1_mask", 32'(st_mask));
    step();
    drive(st_inst(FNC_SH), 32'h2000_0000, 32'h0000_BEEF, 1'b0, 1'b0);
    push(32'h3); push(0); push(1);
    #2;
    chk("sh_off0_mask", 32'(st_mask));
    chk("sh_imem_only_dmem", 32'(dmem_wen));
    chk("sh_imem_only_imem", 32'(imem_wen));

    // Stalled store has no side effects
    step();
    drive(st_inst(FNC_SW), 32'h1000_0000, 32'h1111_1111, 1'b1, 1'b0);
    push(0); push(0);
    #2;
    chk("stall_mask", 32'(st_mask));
    chk("stall_dmem", 32'(dmem_wen));

    // TX: store 0x141 while transmitter not ready
    step();
    drive(st_inst(FNC_SW), 32'h8000_0008, 32'h0000_0141, 1'b0, 1'b0);
    push(0);
    #2;
    chk("tx_valid_before", 32'(uart_tx_valid));
    step();
    drive(NOP, 32'h0, 32'h0, 1'b0, 1'b0);
    push(1); push(32'h41); push(0);
    #2;
    chk("tx_valid_full", 32'(uart_tx_valid));
    chk("tx_data_full", 32'(uart_tx_data));
    chk("ctrl_tx_full", uart_ctrl);

    // Second store while full is dropped
    step();
    drive(st_inst(FNC_SB), 32'h8000_0008, 32'h0000_0042, 1'b0, 1'b0);
    step();
    drive(NOP, 32'h0, 32'h0, 1'b0, 1'b0);
    push(1); push(32'h41);
    #2;
    chk("tx_drop_valid", 32'(uart_tx_valid));
    chk("tx_drop_data", 32'(uart_tx_data));

    // Handshake for one cycle
    uart_tx_ready = 1'b1;
    push(1);
    #1;
    chk("tx_hs_cycle_valid", 32'(uart_tx_valid));
    step();
    uart_tx_ready = 1'b0;
    push(0); push(1);
    #2;
    chk("tx_after_hs_valid", 32'(uart_tx_valid));
    chk("ctrl_tx_empty", uart_ctrl);

    // Handshake and new store in the same cycle: store dropped
    step();
    drive(st_inst(FNC_SW), 32'h8000_0008, 32'h0000_0055, 1'b0, 1'b0);
    step();
    drive(NOP, 32'h0, 32'h0, 1'b0, 1'b0);
    push(1); push(32'h55);
    #2;
    chk("tx_refill_valid", 32'(uart_tx_valid));
    chk("tx_refill_data", 32'(uart_tx_data));
    step();
    uart_tx_ready = 1'b1;
    drive(st_inst(FNC_SW), 32'h8000_0008, 32'h0000_0066, 1'b0, 1'b0);
    step();
    uart_tx_ready = 1'b0;
    drive(NOP, 32'h0, 32'h0, 1'b0, 1'b0);
    push(0);
    #2;
    chk("tx_hs_store_drop", 32'(uart_tx_valid));
    step();
    push(0);
    #2;
    chk("tx_hs_store_still_empty", 32'(uart_tx_valid));

    // RX consume: stalled load first, then unstalled
    step();
    uart_rx_valid = 1'b1;
    drive(ld_inst(FNC_LW), 32'h8000_0004, 32'h0, 1'b1, 1'b0);
    push(3); push(0);
    #2;
    chk("ctrl_rx_valid", uart_ctrl);
    chk("rx_ready_stalled", 32'(uart_rx_ready));
    step();
    stall = 1'b0;
    push(1);
    #2;
    chk("rx_ready_pulse", 32'(uart_rx_ready));
    step();
    drive(NOP, 32'h0, 32'h0, 1'b0, 1'b0);
    push(0);
    #2;
    chk("rx_ready_after", 32'(uart_rx_ready));
    step();
    uart_rx_valid = 1'b0;
    drive(ld_inst(FNC_LW), 32'h8000_0004, 32'h0, 1'b0, 1'b0);
    push(0);
    #2;
    chk("rx_ready_no_byte", 32'(uart_rx_ready));

    // Counter clear with a same-cycle retire: clear wins
    step();
    drive(st_inst(FNC_SW), 32'h8000_0018, 32'h0, 1'b0, 1'b1);
    step();
    drive(NOP, 32'h0, 32'h0, 1'b0, 1'b0);
    push(0); push(0);
    #2;
    chk("clr_cycle", cycle_count);
    chk("clr_inst_beats_inc", inst_count);

    // 100 cycles with 40 retires
    for (int i = 0; i < 100; i++) begin
      inst_retire = ((i % 5) < 2);
      step();
    end
    inst_retire = 1'b0;
    push(100); push(40);
    #2;
    chk("run_cycle", cycle_count);
    chk("run_inst", inst_count);

    // Stalled retire is not counted
    inst_retire = 1'b1;
    stall = 1'b1;
    step();
    inst_retire = 1'b0;
    stall = 1'b0;
    push(101); push(40);
    #2;
    chk("stall_ret_cycle", cycle_count);
    chk("stall_ret_inst", inst_count);

    // Clear, then one cycle with a retire
    step();
    drive(st_inst(FNC_SW), 32'h8000_0018, 32'h1234_5678, 1'b0, 1'b0);
    step();
    drive(NOP, 32'h0, 32'h0, 1'b0, 1'b1);
    push(0); push(0);
    #2;
    chk("clr2_cycle", cycle_count);
    chk("clr2_inst", inst_count);
    step();
    inst_retire = 1'b0;
    push(1); push(1);
    #2;
    chk("post_clr_cycle", cycle_count);
    chk("post_clr_inst", inst_count);

    // Async reset with TX full
    step();
    drive(st_inst(FNC_SB), 32'h8000_0008, 32'h0000_0077, 1'b0, 1'b0);
    step();
    drive(NOP, 32'h0, 32'h0, 1'b0, 1'b0);
    push(1);
    #2;
    chk("pre_rst_tx_valid", 32'(uart_tx_valid));
    #1;
    rst_n = 1'b0;
    push(0); push(0); push(0);
    #1;
    chk("async_rst_tx_valid", 32'(uart_tx_valid));
    chk("async_rst_cycle", cycle_count);
    chk("async_rst_inst", inst_count);
    #2;
    rst_n = 1'b1;
    step();
    push(0); push(1);
    #2;
    chk("post_rst_tx_valid", 32'(uart_tx_valid));
    chk("post_rst_cycle", cycle_count);

    // Final report
    if (exp_q.size() != 0) begin
      checks++;
      failures++;
      $display("FAIL scoreboard_leftover: observed=%0d expected=0", exp_q.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
